// File: rtl/mmio_pkg.sv
// Shared register map, CTRL bit layout and status type for the MMIO I/O controller.
package mmio_pkg;

   localparam logic [11:0] OFF_HEX   = 12'h000;
   localparam logic [11:0] OFF_LEDR  = 12'h020;
   localparam logic [11:0] OFF_KDATA = 12'h080;
   localparam logic [11:0] OFF_KCTRL = 12'h084;
   localparam logic [11:0] OFF_SDATA = 12'h090;
   localparam logic [11:0] OFF_SCTRL = 12'h094;
   localparam logic [11:0] OFF_TCNT  = 12'h100;
   localparam logic [11:0] OFF_TLIM  = 12'h104;
   localparam logic [11:0] OFF_TCTRL = 12'h108;

   localparam int RDY = 0;
   localparam int OVR = 1;
   localparam int IE  = 8;

   typedef struct packed {
      logic ie;
      logic ovr;
      logic rdy;
   } io_status_t;

   function automatic logic [31:0] ctrl_word(input io_status_t s);
      logic [31:0] w;
      w      = '0;
      w[RDY] = s.rdy;
      w[OVR] = s.ovr;
      w[IE]  = s.ie;
      return w;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus stability counter; the debounced output only follows
// an input vector that has held still for DEBOUNCE_CYC cycles.
module io_debounce #(
   parameter int WIDTH        = 4,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             changed
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYC);

   logic [WIDTH-1:0] sync_p0, sync_p1, prev_p2;
   logic [CW-1:0]    cnt, cnt_next;
   logic             load;

   // cnt_next is the number of cycles, including this one, that sync_p1 has held its value
   always_comb begin
      if (sync_p1 != prev_p2) cnt_next = CW'(1);
      else if (cnt == CMAX)   cnt_next = CMAX;
      else                    cnt_next = cnt + CW'(1);
      load = (cnt_next == CMAX) && (sync_p1 != dout);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         prev_p2 <= '0;
         cnt     <= '0;
         dout    <= '0;
         changed <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         cnt     <= cnt_next;
         changed <= load;
         if (load) dout <= sync_p1;
      end
   end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped HEX/LEDR outputs and debounced KEY/SW inputs with status and irq.
// Optional timer block is compiled in when MMIO_TIMER_EN is defined.
module mmio_io_ctrl
   import mmio_pkg::*;
#(
   parameter int                 DBITS        = 32,
   parameter logic [DBITS-1:0]   BASEADDR     = 32'hFFFFF000,
   parameter int                 NKEY         = 4,
   parameter int                 NSW          = 10,
   parameter int                 NLEDR        = 10,
   parameter int                 HEXBITS      = 24,
   parameter logic [HEXBITS-1:0] HEXRESET     = 24'hFEDEAD,
   parameter int                 DEBOUNCE_CYC = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DBITS-1:0]   addr,
   input  logic               wr_en,
   input  logic [DBITS-1:0]   wr_data,
   input  logic               rd_en,
   output logic [DBITS-1:0]   rd_data,
   output logic               sel,
   input  logic [NKEY-1:0]    key_n,
   input  logic [NSW-1:0]     sw,
   output logic [HEXBITS-1:0] hex_out,
   output logic [NLEDR-1:0]   ledr_out,
   output logic               irq
);

   logic [NKEY-1:0] kdata;
   logic [NSW-1:0]  sdata;
   logic            kchg, schg;
   io_status_t      kst, sst;
   logic            in_win;
   logic [11:0]     off;
   logic            hit_hex, hit_ledr, hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
   logic            tirq;
   logic            unused_ok;

   // set beats read-clear; a set with ready already high escalates to overrun
   function automatic io_status_t status_next(input io_status_t s, input logic set,
                                              input logic rdy_clr, input logic ctrl_wr,
                                              input logic [DBITS-1:0] wd);
      io_status_t n;
      n = s;
      if (ctrl_wr) begin
         n.ie = wd[IE];
         if (!wd[OVR]) n.ovr = 1'b0;
      end
      if (set) begin
         if (rdy_clr)    n.rdy = 1'b1;
         else if (s.rdy) n.ovr = 1'b1;
         else            n.rdy = 1'b1;
      end else if (rdy_clr) begin
         n.rdy = 1'b0;
      end
      return n;
   endfunction

   io_debounce #(.WIDTH(NKEY), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk(clk), .reset(reset), .din(~key_n), .dout(kdata), .changed(kchg));

   io_debounce #(.WIDTH(NSW), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw (
      .clk(clk), .reset(reset), .din(sw), .dout(sdata), .changed(schg));

   assign in_win    = (addr[DBITS-1:12] == BASEADDR[DBITS-1:12]);
   assign off       = {addr[11:2], 2'b00};
   assign hit_hex   = in_win && (off == OFF_HEX);
   assign hit_ledr  = in_win && (off == OFF_LEDR);
   assign hit_kdata = in_win && (off == OFF_KDATA);
   assign hit_kctrl = in_win && (off == OFF_KCTRL);
   assign hit_sdata = in_win && (off == OFF_SDATA);
   assign hit_sctrl = in_win && (off == OFF_SCTRL);
   assign unused_ok = ^{wr_data, addr[1:0]};

`ifdef MMIO_TIMER_EN
   logic [DBITS-1:0] tcnt, tlim;
   io_status_t       tst;
   logic             hit_tlim, hit_tctrl, twrap;

   assign hit_tlim  = in_win && (off == OFF_TLIM);
   assign hit_tctrl = in_win && (off == OFF_TCTRL);
   assign twrap     = (tlim != '0) && (tcnt == tlim - DBITS'(1));
   assign tirq      = tst.rdy & tst.ie;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt <= '0;
         tlim <= '0;
         tst  <= '0;
      end else begin
         if (wr_en && hit_tlim) begin
            tlim <= wr_data;
            tcnt <= '0;
         end else if (twrap) begin
            tcnt <= '0;
         end else if (tlim != '0) begin
            tcnt <= tcnt + DBITS'(1);
         end
         tst <= status_next(tst, twrap, wr_en && hit_tctrl && !wr_data[RDY],
                            wr_en && hit_tctrl, wr_data);
      end
   end
`else
   assign tirq = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      sel     = 1'b0;
      if (in_win) begin
         sel = 1'b1;
         case (off)
            OFF_HEX:   rd_data = DBITS'(hex_out);
            OFF_LEDR:  rd_data = DBITS'(ledr_out);
            OFF_KDATA: rd_data = DBITS'(kdata);
            OFF_KCTRL: rd_data = DBITS'(ctrl_word(kst));
            OFF_SDATA: rd_data = DBITS'(sdata);
            OFF_SCTRL: rd_data = DBITS'(ctrl_word(sst));
`ifdef MMIO_TIMER_EN
            OFF_TCNT:  rd_data = tcnt;
            OFF_TLIM:  rd_data = tlim;
            OFF_TCTRL: rd_data = DBITS'(ctrl_word(tst));
`endif
            default:   sel = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_out  <= HEXRESET;
         ledr_out <= '0;
         kst      <= '0;
         sst      <= '0;
      end else begin
         if (wr_en && hit_hex)  hex_out  <= wr_data[HEXBITS-1:0];
         if (wr_en && hit_ledr) ledr_out <= wr_data[NLEDR-1:0];
         kst <= status_next(kst, kchg, rd_en && hit_kdata, wr_en && hit_kctrl, wr_data);
         sst <= status_next(sst, schg, rd_en && hit_sdata, wr_en && hit_sctrl, wr_data);
      end
   end

   assign irq = (kst.rdy & kst.ie) | (sst.rdy & sst.ie) | tirq;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl (DEBOUNCE_CYC=4) with a history-based reference model.
`timescale 1ns/100ps
module tb_mmio_io_ctrl;

   localparam int DEB = 4;
   localparam logic [31:0] A_HEX   = 32'hFFFFF000;
   localparam logic [31:0] A_LEDR  = 32'hFFFFF020;
   localparam logic [31:0] A_KDATA = 32'hFFFFF080;
   localparam logic [31:0] A_KCTRL = 32'hFFFFF084;
   localparam logic [31:0] A_SDATA = 32'hFFFFF090;
   localparam logic [31:0] A_SCTRL = 32'hFFFFF094;

   logic        clk, reset;
   logic [31:0] addr, wr_data, rd_data;
   logic        wr_en, rd_en, sel, irq;
   logic [3:0]  key_n;
   logic [9:0]  sw;
   logic [23:0] hex_out;
   logic [9:0]  ledr_out;

   int n_vec = 0;
   int n_err = 0;

   mmio_io_ctrl #(.DEBOUNCE_CYC(DEB)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .sel(sel), .key_n(key_n), .sw(sw),
      .hex_out(hex_out), .ledr_out(ledr_out), .irq(irq));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model (index 0 = KEY, 1 = SW) ----------------
   logic [31:0] m_s0 [2];
   logic [31:0] m_s1 [2];
   logic [31:0] m_deb [2];
   logic [31:0] m_hist [2][DEB];
   int          m_fill [2];
   bit          m_chg [2], m_rdy [2], m_ovr [2], m_ie [2];
   logic [23:0] m_hex;
   logic [9:0]  m_ledr;
   logic [31:0] raw_v [2];
   logic [11:0] m_off;
   bit          m_win, m_rdclr, m_cw, m_set, m_same;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hex  = 24'hFEDEAD;
         m_ledr = '0;
         for (int c = 0; c < 2; c++) begin
            m_s0[c] = '0; m_s1[c] = '0; m_deb[c] = '0; m_fill[c] = 0;
            m_chg[c] = 0; m_rdy[c] = 0; m_ovr[c] = 0; m_ie[c] = 0;
         end
      end else begin
         raw_v[0] = {28'b0, ~key_n};
         raw_v[1] = {22'b0, sw};
         m_off = {addr[11:2], 2'b00};
         m_win = (addr[31:12] == 20'hFFFFF);
         for (int c = 0; c < 2; c++) begin
            m_rdclr = rd_en && m_win && (m_off == (c == 0 ? 12'h080 : 12'h090));
            m_cw    = wr_en && m_win && (m_off == (c == 0 ? 12'h084 : 12'h094));
            m_set   = m_chg[c];
            if (m_cw) begin
               m_ie[c] = wr_data[8];
               if (!wr_data[1]) m_ovr[c] = 0;
            end
            if (m_set && m_rdclr)  m_rdy[c] = 1;
            else if (m_set) begin
               if (m_rdy[c]) m_ovr[c] = 1;
               else          m_rdy[c] = 1;
            end else if (m_rdclr) m_rdy[c] = 0;
            // last DEB synchronised samples; accept when all agree and differ
            for (int i = DEB - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
            m_hist[c][0] = m_s1[c];
            if (m_fill[c] < DEB) m_fill[c]++;
            m_same = (m_fill[c] == DEB);
            for (int i = 1; i < DEB; i++) if (m_hist[c][i] != m_hist[c][0]) m_same = 0;
            m_chg[c] = m_same && (m_hist[c][0] != m_deb[c]);
            if (m_chg[c]) m_deb[c] = m_hist[c][0];
            m_s1[c] = m_s0[c];
            m_s0[c] = raw_v[c];
         end
         if (wr_en && m_win && m_off == 12'h000) m_hex  = wr_data[23:0];
         if (wr_en && m_win && m_off == 12'h020) m_ledr = wr_data[9:0];
      end
   end

   function automatic logic [31:0] ctrlw(input int c);
      return {23'b0, m_ie[c], 6'b0, m_ovr[c], m_rdy[c]};
   endfunction

   function automatic logic [32:0] exp_bus(input logic [31:0] a);
      logic [11:0] o;
      o = {a[11:2], 2'b00};
      if (a[31:12] != 20'hFFFFF) return 33'b0;
      case (o)
         12'h000: return {1'b1, 8'b0, m_hex};
         12'h020: return {1'b1, 22'b0, m_ledr};
         12'h080: return {1'b1, m_deb[0]};
         12'h084: return {1'b1, ctrlw(0)};
         12'h090: return {1'b1, m_deb[1]};
         12'h094: return {1'b1, ctrlw(1)};
         default: return 33'b0;
      endcase
   endfunction

   logic [32:0] e;
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         e = exp_bus(addr);
         chk("rd_data", rd_data, e[31:0]);
         chk("sel", {31'b0, sel}, {31'b0, e[32]});
         chk("hex_out", {8'b0, hex_out}, {8'b0, m_hex});
         chk("ledr_out", {22'b0, ledr_out}, {22'b0, m_ledr});
         chk("irq", {31'b0, irq},
             {31'b0, (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1])});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wr_data = d; wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic rdclr(input logic [31:0] a);
      addr = a; rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #0.5;
      chk(nm, rd_data, exp);
   endtask

   initial begin
      reset = 1'b1; addr = '0; wr_data = '0; wr_en = 1'b0; rd_en = 1'b0;
      key_n = 4'hF; sw = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick(1);

      peek("rd_hex_reset", A_HEX, 32'h00FEDEAD);
      chk("sel_hex", {31'b0, sel}, 32'd1);
      peek("rd_ledr_reset", A_LEDR, 32'h0);
      chk("sel_ledr", {31'b0, sel}, 32'd1);
      peek("rd_unmapped", 32'hFFFFF040, 32'h0);
      chk("sel_unmapped", {31'b0, sel}, 32'd0);
      peek("rd_out_of_window", 32'h00000000, 32'h0);
      chk("irq_reset", {31'b0, irq}, 32'd0);

      wr(A_HEX, 32'h00123456);
      chk("hex_written", {8'b0, hex_out}, 32'h00123456);
      wr(A_LEDR, 32'h000003FF);
      chk("ledr_written", {22'b0, ledr_out}, 32'h3FF);
      peek("rd_hex_unaligned", 32'hFFFFF003, 32'h00123456);
      wr(A_KDATA, 32'h0000000F);
      peek("kdata_ro", A_KDATA, 32'h0);

      sw = 10'h005;
      tick(5);
      peek("sdata_not_yet", A_SDATA, 32'h0);
      tick(1);
      peek("sdata_after_6", A_SDATA, 32'h5);
      peek("sctrl_before_set", A_SCTRL, 32'h0);
      tick(1);
      peek("sctrl_ready", A_SCTRL, 32'h1);

      rdclr(A_SDATA);
      peek("sctrl_cleared", A_SCTRL, 32'h0);
      sw = 10'h3FA;
      tick(3);
      sw = 10'h005;
      tick(10);
      peek("sdata_glitch", A_SDATA, 32'h5);
      peek("sctrl_glitch", A_SCTRL, 32'h0);

      wr(A_KCTRL, 32'h100);
      peek("kctrl_ie", A_KCTRL, 32'h100);
      key_n = 4'b1011;
      tick(7);
      peek("kdata_press", A_KDATA, 32'h4);
      peek("kctrl_press", A_KCTRL, 32'h101);
      chk("irq_press", {31'b0, irq}, 32'd1);
      rdclr(A_KDATA);
      peek("kctrl_readclr", A_KCTRL, 32'h100);
      chk("irq_readclr", {31'b0, irq}, 32'd0);

      wr(A_KCTRL, 32'h000);
      key_n = 4'hF;
      tick(7);
      peek("kctrl_first", A_KCTRL, 32'h001);
      key_n = 4'b1110;
      tick(7);
      peek("kdata_second", A_KDATA, 32'h1);
      peek("kctrl_overrun", A_KCTRL, 32'h003);
      wr(A_KCTRL, 32'h002);
      peek("kctrl_w1_keeps", A_KCTRL, 32'h003);
      wr(A_KCTRL, 32'h000);
      peek("kctrl_w0_clears", A_KCTRL, 32'h001);

      key_n = 4'hF;
      tick(6);
      rdclr(A_KDATA);
      peek("kdata_collide", A_KDATA, 32'h0);
      peek("kctrl_collide", A_KCTRL, 32'h001);
      rdclr(A_KDATA);
      peek("kctrl_plain_clr", A_KCTRL, 32'h000);

      key_n = 4'b0111;
      tick(3);
      reset = 1'b1;
      key_n = 4'hF;
      tick(2);
      reset = 1'b0;
      tick(12);
      peek("kdata_after_rst", A_KDATA, 32'h0);
      peek("kctrl_after_rst", A_KCTRL, 32'h0);
      peek("hex_after_rst", A_HEX, 32'h00FEDEAD);
      peek("sdata_held_sw", A_SDATA, 32'h5);
      peek("sctrl_held_sw", A_SCTRL, 32'h1);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
